// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic/cmp, iterative shift-add multiply
// and restoring divide, with valid/ready handshakes and registered flags.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] res_q, res_d, rhi_q, rhi_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
   logic [WIDTH:0]   sum, diff, madd, rshift, rtrial;
   logic             ge;

   assign sum    = {1'b0, in_a} + {1'b0, in_b};
   assign diff   = {1'b0, in_a} - {1'b0, in_b};
   // a_q holds the multiplicand for mul and the divisor for div
   assign madd   = {1'b0, hi_q} + ({1'b0, a_q} & {(WIDTH + 1){b_q[0]}});
   assign rshift = {hi_q, lo_q[WIDTH-1]};
   assign rtrial = rshift - {1'b0, a_q};
   assign ge     = ~rtrial[WIDTH];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      rhi_d   = rhi_q;
      c_d     = c_q;
      z_d     = z_q;
      n_d     = n_q;
      v_d     = v_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d  = op;
               a_d   = (op == OP_DIV) ? in_b : in_a;
               b_d   = in_b;
               hi_d  = '0;
               lo_d  = (op == OP_DIV) ? in_a : '0;
               cnt_d = '0;
               rhi_d = '0;
               c_d   = 1'b0;
               v_d   = 1'b0;
               state_d = DONE;
               case (op)
                  OP_ADD: begin
                     res_d = sum[WIDTH-1:0];
                     c_d   = sum[WIDTH];
                     v_d   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
                  end
                  OP_SUB, OP_CMP: begin
                     res_d = (op == OP_SUB) ? diff[WIDTH-1:0] : '0;
                     c_d   = diff[WIDTH];
                     v_d   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
                  end
                  OP_AND:  res_d = in_a & in_b;
                  OP_OR:   res_d = in_a | in_b;
                  OP_XOR:  res_d = in_a ^ in_b;
                  OP_MUL:  state_d = BUSY;
                  default: begin
                     if (in_b == '0) begin
                        res_d = '1;
                        rhi_d = in_a;
                        v_d   = 1'b1;
                     end else begin
                        state_d = BUSY;
                     end
                  end
               endcase
               z_d = (op == OP_CMP) ? (diff[WIDTH-1:0] == '0) : (res_d == '0);
               n_d = (op == OP_CMP) ? diff[WIDTH-1] : res_d[WIDTH-1];
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_q == OP_MUL) begin
               hi_d = madd[WIDTH:1];
               lo_d = {madd[0], lo_q[WIDTH-1:1]};
               b_d  = b_q >> 1;
            end else begin
               hi_d = ge ? rtrial[WIDTH-1:0] : rshift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], ge};
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               res_d   = lo_d;
               rhi_d   = hi_d;
               c_d     = 1'b0;
               n_d     = lo_d[WIDTH-1];
               z_d     = (op_q == OP_MUL) ? ({hi_d, lo_d} == '0) : (lo_d == '0);
               v_d     = (op_q == OP_MUL) && (hi_d != '0);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         rhi_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         rhi_q   <= rhi_d;
         c_q     <= c_d;
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign result_hi = rhi_q;
   assign flag_c    = c_q;
   assign flag_z    = z_q;
   assign flag_n    = n_q;
   assign flag_v    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=8 instance against a cycle-level behavioural model,
// plus a WIDTH=16 instance for wide multiply/divide.
module tb_alu_seq;
   typedef struct packed {
      logic [15:0] res;
      logic [15:0] hi;
      logic        c, z, n, v;
      logic [7:0]  lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [2:0]  op = '0;
   logic [7:0]  in_a = '0, in_b = '0, result, result_hi;
   logic        fc, fz, fn, fv;
   logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
   logic [2:0]  op16 = '0;
   logic [15:0] in_a16 = '0, in_b16 = '0, result16, result_hi16;
   logic        fc16, fz16, fn16, fv16;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi),
      .flag_c(fc), .flag_z(fz), .flag_n(fn), .flag_v(fv)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
      .in_a(in_a16), .in_b(in_b16), .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .result_hi(result_hi16),
      .flag_c(fc16), .flag_z(fz16), .flag_n(fn16), .flag_v(fv16)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference results straight from the arithmetic definitions.
   function automatic exp_t model(input int w, input logic [2:0] o,
                                  input logic [15:0] a16, input logic [15:0] b16);
      longint unsigned a = 64'(a16);
      longint unsigned b = 64'(b16);
      longint unsigned mask = (64'd1 << w) - 1;
      longint unsigned msb = 64'd1 << (w - 1);
      longint unsigned r = 0, h = 0, s = 0;
      exp_t e = '0;
      case (o)
         3'd0: begin
            s = a + b; r = s & mask;
            e.c = s > mask;
            e.v = ((a & msb) == (b & msb)) && ((r & msb) != (a & msb));
            e.z = r == 0; e.n = (r & msb) != 0;
         end
         3'd1, 3'd7: begin
            s = (a - b) & mask;
            e.c = a < b;
            e.v = ((a & msb) != (b & msb)) && ((s & msb) != (a & msb));
            e.z = s == 0; e.n = (s & msb) != 0;
            r = (o == 3'd1) ? s : 0;
         end
         3'd2, 3'd3, 3'd4: begin
            r = (o == 3'd2) ? (a & b) : (o == 3'd3) ? (a | b) : (a ^ b);
            e.z = r == 0; e.n = (r & msb) != 0;
         end
         3'd5: begin
            s = a * b; r = s & mask; h = s >> w;
            e.z = s == 0; e.n = (r & msb) != 0; e.v = h != 0;
         end
         default: begin
            if (b == 0) begin
               r = mask; h = a; e.v = 1'b1; e.n = 1'b1;
            end else begin
               r = a / b; h = a % b;
               e.z = r == 0; e.n = (r & msb) != 0;
            end
         end
      endcase
      e.res = r[15:0];
      e.hi  = h[15:0];
      e.lat = (o == 3'd5 || (o == 3'd6 && b != 0)) ? 8'(w + 1) : 8'd1;
      return e;
   endfunction

   // Transaction-level model of the 8-bit unit: busy flag plus remaining latency.
   logic m_busy = 1'b0;
   int   m_left = 0;
   exp_t m_exp = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_left <= 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy <= 1'b1;
            m_exp  <= model(8, op, {8'h0, in_a}, {8'h0, in_b});
            m_left <= int'(model(8, op, {8'h0, in_a}, {8'h0, in_b}).lat) - 1;
         end
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
      end else if (out_ready) begin
         m_busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", 64'(in_ready), 64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_outputs", {result_hi, result, fc, fz, fn, fv}, 64'd0);
      end else begin
         chk("in_ready", 64'(in_ready), 64'(!m_busy));
         chk("out_valid", 64'(out_valid), 64'(m_busy && m_left == 0));
         if (m_busy && m_left == 0) begin
            chk("result", 64'(result), 64'(m_exp.res[7:0]));
            chk("result_hi", 64'(result_hi), 64'(m_exp.hi[7:0]));
            chk("flags", {fc, fz, fn, fv}, {m_exp.c, m_exp.z, m_exp.n, m_exp.v});
         end
      end
   end

   task automatic run(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input int hold, output exp_t got);
      int lat;
      exp_t e;
      e = model(8, o, {8'h0, a}, {8'h0, b});
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; op = o; in_a = a; in_b = b;
      @(negedge clk);
      lat = 1;
      while (!out_valid && lat < 40) begin
         in_valid = 1'($urandom_range(0, 1)); op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
         @(negedge clk);
         lat++;
      end
      chk("latency", 64'(lat), 64'(e.lat));
      got = '0;
      got.res = {8'h0, result}; got.hi = {8'h0, result_hi};
      got.c = fc; got.z = fz; got.n = fn; got.v = fv;
      got.lat = 8'(lat);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1)); op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
         @(negedge clk);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_outputs", {result_hi, result, fc, fz, fn, fv}, {got.hi[7:0], got.res[7:0], got.c, got.z, got.n, got.v});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_in_ready", 64'(in_ready), 64'd1);
      chk("post_out_valid", 64'(out_valid), 64'd0);
      chk("post_result_kept", {result_hi, result}, {got.hi[7:0], got.res[7:0]});
   endtask

   task automatic run16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        output exp_t got);
      int lat;
      exp_t e;
      e = model(16, o, a, b);
      @(negedge clk);
      in_valid16 = 1'b1; op16 = o; in_a16 = a; in_b16 = b;
      @(negedge clk);
      in_valid16 = 1'b0; in_a16 = 16'($urandom); in_b16 = 16'($urandom);
      lat = 1;
      while (!out_valid16 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk("w16_latency", 64'(lat), 64'(e.lat));
      chk("w16_result", 64'(result16), 64'(e.res));
      chk("w16_result_hi", 64'(result_hi16), 64'(e.hi));
      chk("w16_flags", {fc16, fz16, fn16, fv16}, {e.c, e.z, e.n, e.v});
      got = '0;
      got.res = result16; got.hi = result_hi16;
      got.lat = 8'(lat);
   endtask

   function automatic logic [7:0] pick8();
      case ($urandom_range(0, 6))
         0: return 8'h00;
         1: return 8'hFF;
         2: return 8'h80;
         3: return 8'h7F;
         4: return 8'h01;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      exp_t g;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Hand-computed pins of both model and DUT.
      run(3'd0, 8'd200, 8'd100, 0, g);
      chk("add_res", 64'(g.res), 64'd44);
      chk("add_flags", {g.c, g.z, g.n, g.v}, 64'b1000);
      chk("add_lat", 64'(g.lat), 64'd1);
      run(3'd1, 8'd5, 8'd7, 0, g);
      chk("sub_res", 64'(g.res), 64'd254);
      chk("sub_flags", {g.c, g.z, g.n, g.v}, 64'b1010);
      run(3'd7, 8'd9, 8'd9, 0, g);
      chk("cmp_res", 64'(g.res), 64'd0);
      chk("cmp_flags", {g.c, g.z, g.n, g.v}, 64'b0100);
      run(3'd5, 8'd200, 8'd3, 0, g);
      chk("mul_res", {g.hi, g.res}, {16'h0002, 16'h0058});
      chk("mul_flags", {g.c, g.z, g.n, g.v}, 64'b0001);
      chk("mul_lat", 64'(g.lat), 64'd9);
      run(3'd5, 8'd15, 8'd15, 1, g);
      chk("mul15_res", {g.hi, g.res}, {16'h0000, 16'd225});
      chk("mul15_v", 64'(g.v), 64'd0);
      run(3'd6, 8'd100, 8'd7, 0, g);
      chk("div_res", {g.hi, g.res}, {16'd2, 16'd14});
      chk("div_lat", 64'(g.lat), 64'd9);
      run(3'd6, 8'd55, 8'd0, 0, g);
      chk("div0_res", {g.hi, g.res}, {16'd55, 16'h00FF});
      chk("div0_flags", {g.c, g.z, g.n, g.v}, 64'b0011);
      chk("div0_lat", 64'(g.lat), 64'd1);

      // Backpressure with stray in_valid pulses while DONE.
      run(3'd0, 8'd1, 8'd2, 5, g);
      chk("bp_res", 64'(g.res), 64'd3);

      // Reset in the middle of a multiply.
      @(negedge clk);
      in_valid = 1'b1; op = 3'd5; in_a = 8'd200; in_b = 8'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_outputs", {result_hi, result, fc, fz, fn, fv}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(3'd0, 8'd1, 8'd1, 0, g);
      chk("post_reset_add", 64'(g.res), 64'd2);

      // Randomized traffic, boundary operands favoured.
      for (int i = 0; i < 80; i++) begin
         run(3'($urandom), pick8(), pick8(), int'($urandom_range(0, 3)), g);
      end

      // Wide instance.
      run16(3'd5, 16'hFFFF, 16'hFFFF, g);
      chk("w16_mul_lit", {g.hi, g.res}, {16'hFFFE, 16'h0001});
      chk("w16_mul_lat", 64'(g.lat), 64'd17);
      for (int i = 0; i < 12; i++) begin
         run16(3'($urandom), 16'($urandom), (i == 3) ? 16'h0 : 16'($urandom), g);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
